// File: rtl/cpu32_mem_pkg.sv
// Shared types and constants for the CPU32 unified-memory port arbiter.
package cpu32_mem_pkg;
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic REQ_FETCH   = 1'b0;
    localparam logic REQ_DATA    = 1'b1;
    localparam int   MEM_LAT_MAX = 4;
    localparam int   CNT_W       = $clog2(MEM_LAT_MAX + 1);
endpackage

// File: rtl/mem_arb_pick.sv
// Two-requester winner select; MEM_ARB_RR_EN makes ties go to the requester
// not granted most recently, otherwise DATA always wins a tie.
module mem_arb_pick
    import cpu32_mem_pkg::*;
(
    input  logic en_i,
    input  logic req_fetch_i,
    input  logic req_data_i,
    input  logic last_i,
    output logic gnt_fetch_o,
    output logic gnt_data_o
);
    logic data_first;

`ifdef MEM_ARB_RR_EN
    assign data_first = (last_i == REQ_FETCH);
`else
    logic unused_last;
    assign unused_last = last_i;
    assign data_first  = 1'b1;
`endif

    assign gnt_data_o  = en_i & req_data_i  & (~req_fetch_i | data_first);
    assign gnt_fetch_o = en_i & req_fetch_i & (~req_data_i  | ~data_first);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between the fetch and load/store ports with a
// single outstanding read. Optional round-robin tie-break: MEM_ARB_RR_EN.
//
// state   | meaning
// IDLE    | no read outstanding, grants allowed
// RD_WAIT | read in flight, grant only in the cycle its data returns
module mem_port_arbiter
    import cpu32_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_gnt;
    logic             expire;
    logic             grant_ok;
    logic             gnt_if;
    logic             gnt_d;
    logic             is_read;

`ifdef MEM_ARB_RR_EN
    logic rr_q;
    assign last_gnt = rr_q;
`else
    assign last_gnt = REQ_FETCH;
`endif

    // Counter holds MEM_LAT..1 while waiting; 1 marks the data-return cycle.
    assign expire   = (state_q == RD_WAIT) && (cnt_q == CNT_W'(1));
    assign grant_ok = ~rst_i & ((state_q == IDLE) | expire);

    mem_arb_pick u_pick (
        .en_i        (grant_ok),
        .req_fetch_i (if_req_i),
        .req_data_i  (d_req_i),
        .last_i      (last_gnt),
        .gnt_fetch_o (gnt_if),
        .gnt_data_o  (gnt_d)
    );

    assign is_read     = gnt_if | (gnt_d & ~d_we_i);
    assign if_gnt_o    = gnt_if;
    assign d_gnt_o     = gnt_d;
    assign mem_en_o    = gnt_if | gnt_d;
    assign mem_we_o    = gnt_d & d_we_i;
    assign mem_addr_o  = gnt_d ? d_addr_i : (gnt_if ? if_addr_i : '0);
    assign mem_wdata_o = gnt_d ? d_wdata_i : '0;

    assign if_rvalid_o = ~rst_i & expire & (owner_q == REQ_FETCH);
    assign d_rvalid_o  = ~rst_i & expire & (owner_q == REQ_DATA);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= REQ_FETCH;
`ifdef MEM_ARB_RR_EN
            rr_q    <= REQ_FETCH;
`endif
        end else begin
            if (state_q == RD_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (expire) begin
                    state_q <= IDLE;
                end
            end
            // A new read issued in the expiry cycle overrides the return to IDLE.
            if (is_read) begin
                state_q <= RD_WAIT;
                cnt_q   <= CNT_W'(MEM_LAT);
                owner_q <= gnt_d ? REQ_DATA : REQ_FETCH;
            end
`ifdef MEM_ARB_RR_EN
            if (gnt_if | gnt_d) begin
                rr_q <= gnt_d ? REQ_DATA : REQ_FETCH;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances with MEM_LAT = 1, 2, 3, each with its own memory model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req    [3];
    logic [31:0] if_addr   [3];
    logic        if_gnt    [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata  [3];
    logic        d_req     [3];
    logic        d_we      [3];
    logic [31:0] d_addr    [3];
    logic [31:0] d_wdata   [3];
    logic        d_gnt     [3];
    logic        d_rvalid  [3];
    logic [31:0] d_rdata   [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h32) ? 32'hDEADBEAF : {24'hA5A5A5, a};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_inst
        logic [31:0] mem  [256];
        bit          wr   [256];
        logic [31:0] pipe [4];
        bit          if_pend, d_pend, viol;

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(k + 1)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .if_req_i    (if_req[k]),
            .if_addr_i   (if_addr[k]),
            .if_gnt_o    (if_gnt[k]),
            .if_rvalid_o (if_rvalid[k]),
            .if_rdata_o  (if_rdata[k]),
            .d_req_i     (d_req[k]),
            .d_we_i      (d_we[k]),
            .d_addr_i    (d_addr[k]),
            .d_wdata_i   (d_wdata[k]),
            .d_gnt_o     (d_gnt[k]),
            .d_rvalid_o  (d_rvalid[k]),
            .d_rdata_o   (d_rdata[k]),
            .mem_en_o    (mem_en[k]),
            .mem_we_o    (mem_we[k]),
            .mem_addr_o  (mem_addr[k]),
            .mem_wdata_o (mem_wdata[k]),
            .mem_rdata_i (mem_rdata[k])
        );

        always @(posedge clk) begin
            if (mem_en[k] && mem_we[k]) begin
                mem[mem_addr[k][7:0]] <= mem_wdata[k];
                wr[mem_addr[k][7:0]]  <= 1'b1;
            end
            if (mem_en[k] && !mem_we[k])
                pipe[0] <= wr[mem_addr[k][7:0]] ? mem[mem_addr[k][7:0]] : init_val(mem_addr[k][7:0]);
            else
                pipe[0] <= 32'h0BAD0BAD;
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_rdata[k] = pipe[k];

        // Requester protocol: a pending request may not drop before its grant.
        always @(negedge clk) begin
            if (!rst && ((if_pend && !if_req[k]) || (d_pend && !d_req[k]))) viol = 1'b1;
            if_pend = !rst && if_req[k] && !if_gnt[k];
            d_pend  = !rst && d_req[k]  && !d_gnt[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_if_gnt",    {31'd0, if_gnt[k]},    32'd0);
        chk("rst_if_rvalid", {31'd0, if_rvalid[k]}, 32'd0);
        chk("rst_if_rdata",  if_rdata[k],           32'd0);
        chk("rst_d_gnt",     {31'd0, d_gnt[k]},     32'd0);
        chk("rst_d_rvalid",  {31'd0, d_rvalid[k]},  32'd0);
        chk("rst_d_rdata",   d_rdata[k],            32'd0);
        chk("rst_mem_en",    {31'd0, mem_en[k]},    32'd0);
        chk("rst_mem_we",    {31'd0, mem_we[k]},    32'd0);
        chk("rst_mem_addr",  mem_addr[k],           32'd0);
        chk("rst_mem_wdata", mem_wdata[k],          32'd0);
    endtask

    initial begin
        logic exp_d, prev_d, drop_d, drop_if;
        prev_d = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        // Instance 0 (MEM_LAT=1): both requesting through reset.
        if_req[0] = 1'b1; if_addr[0] = 32'h07;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h05; d_wdata[0] = 32'h1234;

        @(negedge clk); chk_reset_outputs(0);
        tick();
        @(negedge clk); chk_reset_outputs(0);
        tick();
        rst = 1'b0;

        // Contention: first grant to DATA, then fixed priority or alternation.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 10) begin
`ifdef MEM_ARB_RR_EN
                exp_d = (i % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                chk("cont_d_gnt",  {31'd0, d_gnt[0]},  {31'd0, exp_d});
                chk("cont_if_gnt", {31'd0, if_gnt[0]}, {31'd0, !exp_d});
                if (i > 0) begin
                    chk("cont_d_rvalid",  {31'd0, d_rvalid[0]},  {31'd0, prev_d});
                    chk("cont_if_rvalid", {31'd0, if_rvalid[0]}, {31'd0, !prev_d});
                end
                if (i == 1) begin
                    if (prev_d) chk("cont_d_rdata", d_rdata[0], init_val(8'h05));
                    else        chk("cont_if_rdata", if_rdata[0], init_val(8'h07));
                end
                prev_d = exp_d;
            end
            drop_d  = (i >= 9) && d_gnt[0];
            drop_if = (i >= 9) && if_gnt[0];
            tick();
            if (drop_d)  d_req[0]  = 1'b0;
            if (drop_if) if_req[0] = 1'b0;
        end
        chk("cont_drained_if", {31'd0, if_req[0]}, 32'd0);
        chk("cont_drained_d",  {31'd0, d_req[0]},  32'd0);

        // Single fetch, MEM_LAT=2.
        if_req[1] = 1'b1; if_addr[1] = 32'h132;
        @(negedge clk);
        chk("sf_if_gnt",   {31'd0, if_gnt[1]},   32'd1);
        chk("sf_mem_en",   {31'd0, mem_en[1]},   32'd1);
        chk("sf_mem_we",   {31'd0, mem_we[1]},   32'd0);
        chk("sf_mem_addr", mem_addr[1],          32'h132);
        chk("sf_d_rvalid", {31'd0, d_rvalid[1]}, 32'd0);
        tick(); if_req[1] = 1'b0;
        @(negedge clk);
        chk("sf_if_gnt_t1",   {31'd0, if_gnt[1]},    32'd0);
        chk("sf_if_rvalid_t1", {31'd0, if_rvalid[1]}, 32'd0);
        chk("sf_d_rvalid_t1", {31'd0, d_rvalid[1]},  32'd0);
        tick();
        @(negedge clk);
        chk("sf_if_rvalid", {31'd0, if_rvalid[1]}, 32'd1);
        chk("sf_if_rdata",  if_rdata[1],           32'hDEADBEAF);
        chk("sf_d_rvalid2", {31'd0, d_rvalid[1]},  32'd0);
        tick();
        @(negedge clk);
        chk("sf_if_rvalid_t3", {31'd0, if_rvalid[1]}, 32'd0);

        // Store then load of the same address, MEM_LAT=2.
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h10; d_wdata[1] = 32'h22888;
        @(negedge clk);
        chk("st_d_gnt",     {31'd0, d_gnt[1]},  32'd1);
        chk("st_mem_we",    {31'd0, mem_we[1]}, 32'd1);
        chk("st_mem_addr",  mem_addr[1],        32'h10);
        chk("st_mem_wdata", mem_wdata[1],       32'h22888);
        tick(); d_we[1] = 1'b0;
        @(negedge clk);
        chk("ld_d_gnt",    {31'd0, d_gnt[1]},    32'd1);
        chk("ld_mem_we",   {31'd0, mem_we[1]},   32'd0);
        chk("ld_d_rvalid0", {31'd0, d_rvalid[1]}, 32'd0);
        tick(); d_req[1] = 1'b0;
        @(negedge clk);
        chk("ld_d_rvalid1", {31'd0, d_rvalid[1]}, 32'd0);
        tick();
        @(negedge clk);
        chk("ld_d_rvalid",  {31'd0, d_rvalid[1]},  32'd1);
        chk("ld_d_rdata",   d_rdata[1],            32'h22888);
        chk("ld_if_rvalid", {31'd0, if_rvalid[1]}, 32'd0);
        tick();

        // Back-to-back fetches, MEM_LAT=3.
        if_addr[2] = 32'h40;
        for (int i = 0; i < 10; i++) begin
            if_req[2] = (i <= 6);
            @(negedge clk);
            chk("b2b_if_gnt",    {31'd0, if_gnt[2]},    {31'd0, (i % 3 == 0) && (i <= 6)});
            chk("b2b_if_rvalid", {31'd0, if_rvalid[2]}, {31'd0, (i % 3 == 0) && (i > 0)});
            tick();
        end
        if_req[2] = 1'b0;
        tick(); tick(); tick();

        // Reset in the cycle after a MEM_LAT=3 fetch grant.
        if_req[2] = 1'b1; if_addr[2] = 32'h50;
        @(negedge clk);
        chk("rmr_if_gnt", {31'd0, if_gnt[2]}, 32'd1);
        tick(); if_req[2] = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rmr_if_rvalid_rst", {31'd0, if_rvalid[2]}, 32'd0);
        chk("rmr_mem_en_rst",    {31'd0, mem_en[2]},    32'd0);
        tick(); rst = 1'b0; if_req[2] = 1'b1; if_addr[2] = 32'h51;
        @(negedge clk);
        chk("rmr_regrant",       {31'd0, if_gnt[2]},    32'd1);
        chk("rmr_if_rvalid_t2",  {31'd0, if_rvalid[2]}, 32'd0);
        tick(); if_req[2] = 1'b0;
        @(negedge clk);
        chk("rmr_no_stale_t3",   {31'd0, if_rvalid[2]}, 32'd0);
        tick();
        @(negedge clk);
        chk("rmr_if_rvalid_t4",  {31'd0, if_rvalid[2]}, 32'd0);
        tick();
        @(negedge clk);
        chk("rmr_if_rvalid_t5",  {31'd0, if_rvalid[2]}, 32'd1);
        chk("rmr_if_rdata_t5",   if_rdata[2],           init_val(8'h51));
        tick();

        chk("protocol", {29'd0, g_inst[2].viol, g_inst[1].viol, g_inst[0].viol}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous word memory between the CPU32 instruction-fetch port and the load/store port (ldr/str).
- Sits between the processor core and the program/data memory. Lets the processor run from a unified memory instead of a separate combinational ROM.
- Owns request selection, the read-latency countdown and routing of the return data.

Parameters:
AW, 32, address width in words
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles (legal 1..4); mem_rdata is valid MEM_LAT cycles after the mem_en cycle

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DW  fetch data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid, one-cycle pulse
d_rdata  out  DW  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, RD_WAIT. On reset: state IDLE; latency counter 0; owner = FETCH; RR pointer = FETCH (so DATA wins the first tie). Reset drives every output to 0 (gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata).
- Grant is combinational and allowed in:
  - IDLE; or
  - RD_WAIT in the cycle the counter expires (the rvalid cycle).
- Selection:
  - Only one requester active: it wins.
  - Both active: DATA wins (fixed priority; see Optional Feature).
  - The winner's gnt, mem_en, mem_addr and mem_we (mem_we = d_we for DATA, 0 for FETCH) are driven in the grant cycle T. mem_wdata = d_wdata when DATA is granted.
- Store (DATA, d_we=1):
  - Completes in cycle T. No rvalid. State stays or returns to IDLE.
  - A new grant is allowed in cycle T+1.
- Read (fetch, or load with d_we=0):
  - At the T edge: owner latched, counter loaded with MEM_LAT, state goes to RD_WAIT.
  - Counter decrements each cycle.
  - In cycle T+MEM_LAT: the owner's rvalid = 1 and rdata = mem_rdata (combinational pass-through). The non-owner's rvalid stays 0.
  - If no grant happens in that cycle, the next state is IDLE.
- Throughput:
  - Back-to-back reads: one per MEM_LAT cycles.
  - Store after read: issued in the read's rvalid cycle.
- Only one read is ever outstanding. While in RD_WAIT before expiry, both gnt are 0 and the requests are held.
- rst asserted mid-read: the pending rvalid is dropped. The state returns to IDLE the next cycle, and no stale data is delivered.
- A request deasserting before its grant is a protocol violation; the bench asserts against it.
- Address and data widths pass through unmodified. No arithmetic beyond the 3-bit latency counter.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - On a tie, the winner is the requester not granted most recently. The RR pointer updates on every grant.
  - Guarantees that fetch is never starved by a load/store loop.
- Undefined:
  - Fixed DATA > FETCH priority. No RR pointer register.

Decomposition:
- Package cpu32_mem_pkg:
  - State enum (IDLE, RD_WAIT).
  - Requester id constants REQ_FETCH=0, REQ_DATA=1.
  - MEM_LAT_MAX=4 and the counter width.
- Sub-module mem_arb_pick:
  - Combinational winner select from the two req bits, an enable, and the RR pointer (the pointer is ignored when MEM_ARB_RR_EN is undefined).
  - The FSM and counter stay in mem_port_arbiter.

Test Plan:
- Reset: hold rst 2 cycles with both req=1 -> all outputs 0; first grant in the cycle after rst falls goes to DATA.
- Single fetch, MEM_LAT=2: if_req, if_addr=0x132 at cycle 5 -> if_gnt@5, mem_addr=0x132@5; memory returns 0xDEADBEAF -> if_rvalid=1, if_rdata=0xDEADBEAF@7; d_rvalid=0 throughout.
- Store then load same address: d_we=1, d_addr=0x10, d_wdata=0x22888 granted @T -> mem_we=1@T; load 0x10 granted @T+1 -> d_rvalid with 0x22888 @T+1+MEM_LAT.
- Contention, 10 cycles, both requesting continuously with MEM_LAT=1:
  - Without MEM_ARB_RR_EN: only DATA granted.
  - With MEM_ARB_RR_EN: grants alternate DATA, FETCH, DATA, ...
- Back-to-back reads, MEM_LAT=3 -> grants at T, T+3, T+6; rvalid at T+3, T+6, T+9; no gnt in between.
- Reset mid-read: rst at T+1 of a MEM_LAT=3 read -> no rvalid at T+3; state IDLE; next request granted normally.
